// File: rtl/sysu_gate_bank_dg.sv
// -----------------------------------------------------------------------------
// sysu_gate_bank_dg
//   Bank of CH gates with FANIN inputs each and a run-time selectable gate
//   function. Each gate output is registered and deglitched: it changes only
//   after the new gate result has been seen on STABLE+1 consecutive edges.
//   A one-cycle change flag accompanies each output update.
//
// Ports
//   CLK      in   1         rising-edge clock
//   RST_N    in   1         asynchronous reset, active low
//   MODE_WE  in   1         write strobe for MODE_IN
//   MODE_IN  in   3         gate function to load (6 and 7 are ignored)
//   MODE     out  3         current gate function
//   IN       in   CH*FANIN  gate inputs; channel i uses IN[i*FANIN +: FANIN]
//   Y        out  CH        deglitched registered gate outputs
//   CHG      out  CH        one-cycle pulse when Y[i] updates
// -----------------------------------------------------------------------------
module sysu_gate_bank_dg #(
  parameter int CH     = 3,
  parameter int FANIN  = 3,
  parameter int STABLE = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  MODE_WE,
  input  logic [2:0]            MODE_IN,
  output logic [2:0]            MODE,
  input  logic [CH*FANIN-1:0]   IN,
  output logic [CH-1:0]         Y,
  output logic [CH-1:0]         CHG
);

  localparam int CW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE);

  typedef enum logic [2:0] {
    MODE_NAND = 3'd0,
    MODE_AND  = 3'd1,
    MODE_NOR  = 3'd2,
    MODE_OR   = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5
  } gate_mode_e;

  gate_mode_e               mode_q, mode_d;
  logic [CH-1:0]            y_q, y_d;
  logic [CH-1:0]            chg_q, chg_d;
  logic [CH-1:0][CW-1:0]    cnt_q, cnt_d;

  logic [CH-1:0]            raw;
  logic [FANIN-1:0]         ch_in;
  logic                     mode_load;

  // Reserved encodings are dropped entirely, so the filter keeps running as
  // if no write had been attempted.
  assign mode_load = MODE_WE && (MODE_IN < 3'd6);

  // Gate function, evaluated with the registered mode.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    raw   = '0;
    ch_in = '0;
    for (int i = 0; i < CH; i++) begin
      ch_in = IN[i*FANIN +: FANIN];
      unique case (mode_q)
        MODE_NAND: raw[i] = ~(&ch_in);
        MODE_AND:  raw[i] =   &ch_in;
        MODE_NOR:  raw[i] = ~(|ch_in);
        MODE_OR:   raw[i] =   |ch_in;
        MODE_XOR:  raw[i] =   ^ch_in;
        MODE_XNOR: raw[i] = ~(^ch_in);
        default:   raw[i] = 1'b1;
      endcase
    end
  end

  // Next-state: a legal mode write restarts every filter and freezes Y for
  // that edge; otherwise each channel counts consecutive differing samples.
  always_comb begin
    mode_d = mode_q;
    y_d    = y_q;
    chg_d  = '0;
    cnt_d  = cnt_q;
    if (mode_load) begin
      mode_d = gate_mode_e'(MODE_IN);
      cnt_d  = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (raw[i] == y_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == STABLE_CNT) begin
          y_d[i]   = raw[i];
          chg_d[i] = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= MODE_NAND;
      y_q    <= '1;
      chg_q  <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mode_q <= mode_d;
      y_q    <= y_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign MODE = mode_q;
  assign Y    = y_q;
  assign CHG  = chg_q;

endmodule

// File: tb/tb_sysu_gate_bank_dg.sv
// -----------------------------------------------------------------------------
// tb_sysu_gate_bank_dg
//   Drives a STABLE=0 and a STABLE=2 build of sysu_gate_bank_dg from the same
//   stimulus. A behavioural model (gate function by ones-count, filter as a
//   run length of disagreeing samples) is compared against both builds on
//   every falling edge; directed literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_sysu_gate_bank_dg;

  localparam int CH    = 3;
  localparam int FANIN = 3;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                mode_we = 1'b0;
  logic [2:0]          mode_in = 3'd0;
  logic [CH*FANIN-1:0] in_v    = '0;

  logic [2:0]    mode0, mode2;
  logic [CH-1:0] y0, y2, chg0, chg2;

  sysu_gate_bank_dg #(.CH(CH), .FANIN(FANIN), .STABLE(0)) dut_s0 (
    .CLK(clk), .RST_N(rst_n), .MODE_WE(mode_we), .MODE_IN(mode_in),
    .MODE(mode0), .IN(in_v), .Y(y0), .CHG(chg0)
  );

  sysu_gate_bank_dg #(.CH(CH), .FANIN(FANIN), .STABLE(2)) dut_s2 (
    .CLK(clk), .RST_N(rst_n), .MODE_WE(mode_we), .MODE_IN(mode_in),
    .MODE(mode2), .IN(in_v), .Y(y2), .CHG(chg2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]    m_mode = 3'd0;
  logic [CH-1:0] m_y   [2] = '{3'b111, 3'b111};
  logic [CH-1:0] m_chg [2] = '{3'b000, 3'b000};
  int            m_run [2][CH];

  function automatic int stable_of(input int b);
    return (b == 0) ? 0 : 2;
  endfunction

  function automatic logic gate_fn(input logic [2:0] mode, input logic [FANIN-1:0] bits);
    int ones;
    ones = $countones(bits);
    case (mode)
      3'd0:    return ones != FANIN;
      3'd1:    return ones == FANIN;
      3'd2:    return ones == 0;
      3'd3:    return ones != 0;
      3'd4:    return (ones % 2) == 1;
      3'd5:    return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 3'd0;
    for (int b = 0; b < 2; b++) begin
      m_y[b]   = '1;
      m_chg[b] = '0;
      for (int c = 0; c < CH; c++) m_run[b][c] = 0;
    end
  endtask

  task automatic model_step();
    logic       legal;
    logic [2:0] old_mode;
    logic       r;
    legal    = mode_we && (mode_in < 3'd6);
    old_mode = m_mode;
    if (legal) m_mode = mode_in;
    for (int b = 0; b < 2; b++) begin
      m_chg[b] = '0;
      for (int c = 0; c < CH; c++) begin
        if (legal) begin
          m_run[b][c] = 0;
        end else begin
          r = gate_fn(old_mode, in_v[c*FANIN +: FANIN]);
          if (r == m_y[b][c]) begin
            m_run[b][c] = 0;
          end else if (m_run[b][c] >= stable_of(b)) begin
            m_y[b][c]   = r;
            m_chg[b][c] = 1'b1;
            m_run[b][c] = 0;
          end else begin
            m_run[b][c] = m_run[b][c] + 1;
          end
        end
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("mode_s0", mode0, m_mode);
    check("y_s0",    y0,    m_y[0]);
    check("chg_s0",  chg0,  m_chg[0]);
    check("mode_s2", mode2, m_mode);
    check("y_s2",    y2,    m_y[1]);
    check("chg_s2",  chg2,  m_chg[1]);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #12 rst_n = 1'b1;
    step();

    // Reset: build some state (OR mode, all outputs low), then reset mid-cycle.
    mode_we = 1'b1; mode_in = 3'd3;
    step();
    mode_we = 1'b0;
    step(3);
    check("t1_or_y",   y2,   3'b000);
    check("t1_or_chg", chg2, 3'b111);
    #1 rst_n = 1'b0;
    #1;
    check("t1_rst_y",    y2,    3'b111);
    check("t1_rst_mode", mode2, 3'd0);
    check("t1_rst_chg",  chg2,  3'b000);
    check("t1_rst_y_s0", y0,    3'b111);
    #2 rst_n = 1'b1;
    step();

    // NAND default: channel 0 goes 000 -> 111.
    in_v = 9'b000_000_111;
    step(2);
    check("t2_hold_y",   y2,   3'b111);
    check("t2_hold_chg", chg2, 3'b000);
    step();
    check("t2_fall_y",   y2,   3'b110);
    check("t2_fall_chg", chg2, 3'b001);
    step();
    check("t2_after_chg", chg2, 3'b000);
    check("t2_after_y",   y2,   3'b110);

    // Glitch filter: 2-edge pulse discarded, 3-edge pulse accepted.
    in_v[5:3] = 3'b111;
    step(2);
    in_v[5:3] = 3'b000;
    step();
    check("t3_glitch_y",   y2,   3'b110);
    check("t3_glitch_chg", chg2, 3'b000);
    step(2);
    check("t3_glitch_y2",  y2,   3'b110);
    in_v[5:3] = 3'b111;
    step(3);
    check("t3_pulse_y",   y2,   3'b100);
    check("t3_pulse_chg", chg2, 3'b010);
    in_v[5:3] = 3'b000;
    step(2);
    check("t3_rel_hold", y2, 3'b100);
    step();
    check("t3_rel_y",   y2,   3'b110);
    check("t3_rel_chg", chg2, 3'b010);

    // Mode write to XOR.
    in_v = '0;
    step(3);
    check("t4_pre_y", y2, 3'b111);
    in_v    = 9'b000_001_111;
    mode_we = 1'b1; mode_in = 3'd4;
    step();
    mode_we = 1'b0;
    check("t4_mode",  mode2, 3'd4);
    check("t4_w_y",   y2,    3'b111);
    check("t4_w_chg", chg2,  3'b000);
    step(2);
    check("t4_wait_y", y2, 3'b111);
    step();
    check("t4_y",   y2,   3'b011);
    check("t4_chg", chg2, 3'b100);

    // Reserved write leaves mode and the running count alone.
    in_v[2:0] = 3'b110;
    step();
    mode_we = 1'b1; mode_in = 3'd6;
    step();
    mode_we = 1'b0;
    check("t4_rsv_mode", mode2, 3'd4);
    check("t4_rsv_y",    y2,    3'b011);
    step();
    check("t4_rsv_upd_y",   y2,   3'b010);
    check("t4_rsv_upd_chg", chg2, 3'b001);

    // Collision: counter at STABLE on the same edge as a legal write.
    in_v[5:3] = 3'b000;
    step(2);
    mode_we = 1'b1; mode_in = 3'd4;
    step();
    mode_we = 1'b0;
    check("t5_col_y",   y2,   3'b010);
    check("t5_col_chg", chg2, 3'b000);
    step(2);
    check("t5_col_hold", y2, 3'b010);
    step();
    check("t5_col_y2",   y2,   3'b000);
    check("t5_col_chg2", chg2, 3'b010);

    // Reset while a counter is at 1.
    in_v[8:6] = 3'b001;
    step();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    check("t5_rst_y",   y2,   3'b111);
    check("t5_rst_chg", chg2, 3'b000);
    step(2);
    check("t5_rst_chg2", chg2, 3'b000);

    // STABLE=0 build: channel 0 toggles every cycle.
    in_v = '0;
    step();
    for (int k = 1; k <= 8; k++) begin
      in_v[2:0] = k[0] ? 3'b111 : 3'b000;
      step();
      check("t6_y0",   {31'd0, y0[0]}, k[0] ? 32'd0 : 32'd1);
      check("t6_chg0", chg0,           3'b001);
    end
    check("t6_s2_y", y2, 3'b111);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
